// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage between execute and a word-wide synchronous
// data RAM. It handles lb/lh/lw/lbu/lhu/sb/sh/sw, including lane steering,
// sign/zero extension and misalignment flagging.
// The core is stalled while a load is in flight.
// Optional build macro MEM_RMW_EN targets a RAM without byte enables.
// In that build, sub-word stores become a read-merge-write sequence.
module mem_access_unit #(
  parameter int ADDR_W     = 14,
  parameter int RD_LATENCY = 1    // 1..7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [5:0]        opcode,
  input  logic [31:0]       addr_result,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              load_valid,
  output logic              stall,
  output logic              addr_err,
  output logic [31:0]       err_addr,
  output logic              ram_en,
  output logic              ram_wen,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

`ifdef MEM_RMW_EN
  typedef enum logic [2:0] {IDLE, LWAIT, LDONE, RMW_RD, RMW_WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LWAIT, LDONE} state_t;
`endif

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [31:0] cap_data;
  logic [1:0]  cap_off;
  logic [2:0]  cap_op;
  logic [31:0] err_addr_q;
  logic        capture, err_set, rmw_q;
  logic [2:0]  op;
  logic        is_byte, is_half, is_word, misal;
  logic [3:0]  be_lane;
  logic [31:0] wdata_rep, ld_ext;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        unused_bits;

  assign op          = opcode[2:0];
  assign unused_bits = ^opcode[5:3];

  // Size decode, misalignment, byte enables and store-lane replication.
  always_comb begin
    is_byte   = (op == 3'b000) || (op == 3'b100);
    is_half   = (op == 3'b001) || (op == 3'b101);
    is_word   = !(is_byte || is_half);
    misal     = (is_half && addr_result[0]) || (is_word && (addr_result[1:0] != 2'b00));
    be_lane   = 4'b1111;
    wdata_rep = write_data;
    if (is_byte) begin
      be_lane   = 4'b0001 << addr_result[1:0];
      wdata_rep = {4{write_data[7:0]}};
    end else if (is_half) begin
      be_lane   = addr_result[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{write_data[15:0]}};
    end
  end

`ifdef MEM_RMW_EN
  // Merge the new lanes into the word that was read back.
  logic [31:0] merged;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be_lane[i] ? wdata_rep[8*i +: 8] : cap_data[8*i +: 8];
  end

  // This flag marks an LDONE that closes an RMW store, so no load result is presented.
  always_ff @(posedge clock) begin
    if (reset)                rmw_q <= 1'b0;
    else if (state == RMW_WR) rmw_q <= 1'b1;
    else if (state == IDLE)   rmw_q <= 1'b0;
  end
`else
  assign rmw_q = 1'b0;
`endif

  // Next-state logic and RAM/handshake outputs. Reset forces every output low.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    capture   = 1'b0;
    err_set   = 1'b0;
    ram_en    = 1'b0;
    ram_wen   = 1'b0;
    stall     = 1'b0;
    addr_err  = 1'b0;
    ram_be    = be_lane;
    ram_wdata = wdata_rep;
    ram_addr  = addr_result[ADDR_W+1:2];
`ifdef MEM_RMW_EN
    ram_be    = 4'b1111;
`endif
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (misal) begin
            addr_err = 1'b1;
            err_set  = 1'b1;
          end else if (mem_write) begin
`ifdef MEM_RMW_EN
            if (!is_word) begin
              ram_en   = 1'b1;
              stall    = 1'b1;
              state_nx = RMW_RD;
              cnt_nx   = 3'(RD_LATENCY - 1);
            end else
`endif
            begin
              ram_en  = 1'b1;
              ram_wen = 1'b1;
            end
          end else begin
            ram_en   = 1'b1;
            stall    = 1'b1;
            state_nx = LWAIT;
            cnt_nx   = 3'(RD_LATENCY - 1);
          end
        end
      end
      LWAIT: begin
        stall = 1'b1;
        if (cnt == 3'd0) begin
          capture  = 1'b1;
          state_nx = LDONE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
`ifdef MEM_RMW_EN
      RMW_RD: begin
        stall = 1'b1;
        if (cnt == 3'd0) begin
          capture  = 1'b1;
          state_nx = RMW_WR;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      RMW_WR: begin
        stall     = 1'b1;
        ram_en    = 1'b1;
        ram_wen   = 1'b1;
        ram_wdata = merged;
        state_nx  = LDONE;
      end
`endif
      LDONE:   state_nx = IDLE;   // mem_read still high here belongs to the retiring load
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      capture   = 1'b0;
      err_set   = 1'b0;
      ram_en    = 1'b0;
      ram_wen   = 1'b0;
      stall     = 1'b0;
      addr_err  = 1'b0;
      ram_be    = 4'b0000;
      ram_wdata = 32'h0;
      ram_addr  = '0;
    end
  end

  // State, countdown, read capture and sticky error address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      cap_data   <= 32'h0;
      cap_off    <= 2'b00;
      cap_op     <= 3'b000;
      err_addr_q <= 32'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        cap_data <= ram_rdata;
        cap_off  <= addr_result[1:0];
        cap_op   <= op;
      end
      if (err_set) err_addr_q <= addr_result;
    end
  end

  // Load lane select and extension from the captured word.
  always_comb begin
    ld_b = cap_data[8*cap_off +: 8];
    ld_h = cap_off[1] ? cap_data[31:16] : cap_data[15:0];
    case (cap_op)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_ext = {24'h0, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {16'h0, ld_h};
      default: ld_ext = cap_data;
    endcase
  end

  assign load_valid = (state == LDONE) && !rmw_q && !reset;
  assign read_data  = load_valid ? ld_ext : 32'h0;
  assign err_addr   = reset ? 32'h0 : err_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Load results go through a scoreboard queue
// that a negedge monitor drains. A second instance with RD_LATENCY=3 covers reset
// mid-load.
module tb_mem_access_unit;
  localparam int LAT = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, mem_read, mem_write;
  logic [5:0]  opcode;
  logic [31:0] addr_result, write_data, read_data, err_addr, ram_wdata, ram_rdata;
  logic        load_valid, stall, addr_err, ram_en, ram_wen;
  logic [3:0]  ram_be;
  logic [13:0] ram_addr;

  logic        rst3 = 1'b1, rd3 = 1'b0;
  logic [31:0] rdata3, err3, wd3;
  logic        lv3, st3, ae3, en3, wen3;
  logic [3:0]  be3;
  logic [13:0] addr3;
  logic [31:0] ram_rdata3 = 32'h0;
  int          lv3_cnt = 0;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.ADDR_W(14), .RD_LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .opcode(opcode), .addr_result(addr_result), .write_data(write_data),
    .read_data(read_data), .load_valid(load_valid), .stall(stall),
    .addr_err(addr_err), .err_addr(err_addr), .ram_en(ram_en), .ram_wen(ram_wen),
    .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  mem_access_unit #(.ADDR_W(14), .RD_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(rst3), .mem_read(rd3), .mem_write(1'b0),
    .opcode(6'b000011), .addr_result(32'h40), .write_data(32'h0),
    .read_data(rdata3), .load_valid(lv3), .stall(st3),
    .addr_err(ae3), .err_addr(err3), .ram_en(en3), .ram_wen(wen3),
    .ram_be(be3), .ram_addr(addr3), .ram_wdata(wd3), .ram_rdata(ram_rdata3));

  // RAM model: byte-enabled write and LAT-cycle read pipeline.
  logic [31:0] mem [0:63];
  logic [31:0] rpipe [1:LAT];
  always @(posedge clock) begin
    if (ram_en && ram_wen)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_en && !ram_wen) rpipe[1] <= mem[ram_addr[5:0]];
    for (int i = 2; i <= LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[LAT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every load_valid pops one expected value.
  always @(negedge clock) begin
    logic [31:0] e;
    if (load_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got %h expected no load", read_data);
      end else begin
        e = exp_q.pop_front();
        check("load_data", read_data, e);
      end
    end else begin
      check("rdata_zero_when_idle", read_data, 32'h0);
    end
  end

  always @(negedge clock) if (lv3) lv3_cnt++;

  task automatic idle();
    @(posedge clock); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d,
                          input logic rd_too, input logic [3:0] ebe, input logic [31:0] ewd,
                          input int est);
    int n; logic got; logic [3:0] be; logic [31:0] wd; logic [13:0] wa;
    @(posedge clock); #1;
    mem_write = 1'b1; mem_read = rd_too; opcode = {3'b000, op};
    addr_result = a; write_data = d;
    n = 0; got = 1'b0; be = 4'h0; wd = 32'h0; wa = 14'h0;
    @(negedge clock);
    while (1) begin
      if (ram_en && ram_wen) begin got = 1'b1; be = ram_be; wd = ram_wdata; wa = ram_addr; end
      if (!stall || n >= 20) break;
      n++;
      @(negedge clock);
    end
    check("st_wen_seen", 32'(got), 32'd1);
    check("st_be", 32'(be), 32'(ebe));
    check("st_wdata", wd, ewd);
    check("st_waddr", 32'(wa), 32'(a[15:2]));
    check("st_stall_cycles", 32'(n), 32'(est));
    @(posedge clock); #1;
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  // Leaves mem_read high at the LDONE negedge; the next call issues a back-to-back load.
  task automatic do_load(input logic [31:0] a, input logic [2:0] op, input logic [31:0] exp);
    int n;
    @(posedge clock); #1;
    mem_read = 1'b1; mem_write = 1'b0; opcode = {3'b000, op}; addr_result = a;
    exp_q.push_back(exp);
    n = 0;
    @(negedge clock);
    while (stall && n < 20) begin n++; @(negedge clock); end
    check("ld_stall_cycles", 32'(n), 32'(LAT + 1));
    check("ld_valid", 32'(load_valid), 32'd1);
  endtask

  task automatic do_misal(input logic [31:0] a, input logic [2:0] op, input logic st);
    @(posedge clock); #1;
    mem_read = !st; mem_write = st; opcode = {3'b000, op}; addr_result = a;
    @(negedge clock);
    check("mis_addr_err", 32'(addr_err), 32'd1);
    check("mis_stall", 32'(stall), 32'd0);
    check("mis_ram_en", 32'(ram_en), 32'd0);
    @(posedge clock); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    check("mis_err_addr", err_addr, a);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; opcode = 6'b000011;
    addr_result = 32'h31; write_data = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; mem_read = 1'b0;

    do_store(32'h10, 3'b011, 32'hDEADBEEF, 1'b0, 4'hF, 32'hDEADBEEF, 0);
    do_load(32'h10, 3'b011, 32'hDEADBEEF);
    idle();
    do_store(32'h20, 3'b011, 32'h80FF7F01, 1'b0, 4'hF, 32'h80FF7F01, 0);
    do_store(32'h00, 3'b011, 32'h11223344, 1'b0, 4'hF, 32'h11223344, 0);
    do_store(32'h28, 3'b011, 32'h00000000, 1'b0, 4'hF, 32'h00000000, 0);

    do_load(32'h23, 3'b000, 32'hFFFFFF80);
    do_load(32'h23, 3'b100, 32'h00000080);
    do_load(32'h20, 3'b001, 32'h00007F01);
    do_load(32'h22, 3'b001, 32'hFFFF80FF);
    do_load(32'h22, 3'b101, 32'h000080FF);
    do_load(32'h20, 3'b111, 32'h80FF7F01);
    idle();

`ifdef MEM_RMW_EN
    do_store(32'h2A, 3'b001, 32'h1234ABCD, 1'b0, 4'hF, 32'hABCD0000, LAT + 2);
    do_store(32'h29, 3'b000, 32'h55667788, 1'b0, 4'hF, 32'hABCD8800, LAT + 2);
    do_store(32'h01, 3'b000, 32'h000000AA, 1'b0, 4'hF, 32'h1122AA44, LAT + 2);
`else
    do_store(32'h2A, 3'b001, 32'h1234ABCD, 1'b0, 4'b1100, 32'hABCDABCD, 0);
    do_store(32'h29, 3'b000, 32'h55667788, 1'b0, 4'b0010, 32'h88888888, 0);
    do_store(32'h01, 3'b000, 32'h000000AA, 1'b0, 4'b0010, 32'hAAAAAAAA, 0);
`endif
    do_load(32'h28, 3'b011, 32'hABCD8800);
    do_load(32'h00, 3'b011, 32'h1122AA44);
    do_load(32'h29, 3'b100, 32'h00000088);
    idle();

    // A request with both mem_read and mem_write high is a store.
    do_store(32'h30, 3'b011, 32'h0BADF00D, 1'b1, 4'hF, 32'h0BADF00D, 0);
    do_load(32'h30, 3'b011, 32'h0BADF00D);
    idle();

    do_misal(32'h31, 3'b011, 1'b0);
    do_misal(32'h33, 3'b001, 1'b0);
    do_misal(32'h2B, 3'b001, 1'b1);
    do_misal(32'h21, 3'b111, 1'b0);

    // Reset in the second stall cycle of an RD_LATENCY=3 load.
    @(posedge clock); #1 rst3 = 1'b0;
    @(posedge clock); #1 rd3 = 1'b1;
    @(negedge clock);
    check("l3_stall_issue", 32'(st3), 32'd1);
    check("l3_ram_en_issue", 32'(en3), 32'd1);
    @(posedge clock); #1 rst3 = 1'b1;
    @(negedge clock);
    check("l3_rst_stall", 32'(st3), 32'd0);
    check("l3_rst_outs", {ae3, en3, wen3, be3, lv3, 6'h0, addr3, 4'h0},
          32'h0);
    check("l3_rst_data", rdata3 | err3 | wd3, 32'h0);
    @(posedge clock); #1
    rst3 = 1'b0; rd3 = 1'b0;
    @(negedge clock);
    check("l3_post_stall", 32'(st3), 32'd0);
    check("l3_post_ram_en", 32'(en3), 32'd0);
    repeat (8) @(negedge clock);
    check("l3_no_load_valid", 32'(lv3_cnt), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
